// File: rtl/spi_flash_phy.sv
// Single-bit SPI mode-0 master driving the serial flash pins: one byte per f_wr, CS# framing from f_format.
// Optional build macro SPI_MISO_SYNC_EN adds a 2-flop MISO synchronizer and a late (end-of-HIGH) capture point.
module spi_flash_phy #(
    parameter logic [3:0] RATE_POR = 4'h7
) (
    input  logic       clk,
    input  logic       arstn,
    output logic       f_ready,
    input  logic       f_wr,
    input  logic       f_who,
    input  logic [7:0] f_dout,
    input  logic [2:0] f_format,
    input  logic [3:0] f_rate,
    output logic [7:0] f_din,
    output logic       f_owner,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, GUARD} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  rate_q, rate_d;
    logic        first_q, first_d;
    logic [1:0]  fmt_q, fmt_d;
    logic        fill_q, fill_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  din_q, din_d;
    logic        owner_q, owner_d;
    logic        ready_q, ready_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;

    logic [4:0]  h;
    logic        phase_end;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_final;

`ifdef SPI_MISO_SYNC_EN
    logic miso_s1_q, miso_s1_d;
    logic miso_s2_q, miso_s2_d;
`endif

    always_comb begin
        h = {1'b0, rate_q} + 5'd1;
`ifdef SPI_MISO_SYNC_EN
        // The synchronizer needs at least three HIGH clocks to deliver a settled bit.
        if (h < 5'd3) h = 5'd3;
        rx_shift = {rx_q[6:0], miso_s2_q};
        rx_final = rx_shift;
`else
        rx_shift = {rx_q[6:0], spi_miso};
        rx_final = rx_q;
`endif
        phase_end = (cnt_q == h - 5'd1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        rate_d  = rate_q;
        first_d = first_q;
        fmt_d   = fmt_q;
        fill_d  = fill_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        din_d   = din_q;
        owner_d = owner_q;
        ready_d = ready_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
`ifdef SPI_MISO_SYNC_EN
        miso_s1_d = spi_miso;
        miso_s2_d = miso_s1_q;
`endif

        case (state_q)
            IDLE: begin
                if (f_wr) begin
                    owner_d = f_who;
                    rate_d  = first_q ? RATE_POR : f_rate;
                    first_d = 1'b0;
                    cnt_d   = 5'd0;
                    bit_d   = 3'd0;
                    ready_d = 1'b0;
                    sclk_d  = 1'b0;
                    fmt_d   = f_format[1:0];
                    if (f_format[1:0] == 2'b00) begin
                        state_d = GUARD;
                        cs_n_d  = 1'b1;
                    end else begin
                        state_d = LOW;
                        cs_n_d  = 1'b0;
                        fill_d  = f_format[2];
                        shift_d = f_format[2] ? 8'hFF : f_dout;
                        mosi_d  = f_format[2] ? 1'b1 : f_dout[7];
                    end
                end else if (f_format == 3'b000) begin
                    cs_n_d = 1'b1;
                end
            end
            LOW: begin
                cnt_d = cnt_q + 5'd1;
                if (phase_end) begin
                    cnt_d   = 5'd0;
                    state_d = HIGH;
                    sclk_d  = 1'b1;
`ifndef SPI_MISO_SYNC_EN
                    rx_d    = rx_shift;
`endif
                end
            end
            HIGH: begin
                cnt_d = cnt_q + 5'd1;
                if (phase_end) begin
                    cnt_d  = 5'd0;
                    sclk_d = 1'b0;
`ifdef SPI_MISO_SYNC_EN
                    rx_d   = rx_shift;
`endif
                    if (bit_q == 3'd7) begin
                        // Format 01 defers f_din until the guard time has elapsed.
                        if (fmt_q == 2'b01) begin
                            state_d = GUARD;
                            cs_n_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            ready_d = 1'b1;
                            din_d   = rx_final;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = LOW;
                        shift_d = {shift_q[6:0], fill_q};
                        mosi_d  = shift_q[6];
                    end
                end
            end
            GUARD: begin
                cnt_d = cnt_q + 5'd1;
                if (phase_end) begin
                    cnt_d   = 5'd0;
                    state_d = IDLE;
                    ready_d = 1'b1;
                    if (fmt_q != 2'b00) din_d = rx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            bit_q   <= 3'd0;
            rate_q  <= RATE_POR;
            first_q <= 1'b1;
            fmt_q   <= 2'b00;
            fill_q  <= 1'b0;
            shift_q <= 8'h00;
            rx_q    <= 8'h00;
            din_q   <= 8'h00;
            owner_q <= 1'b0;
            ready_q <= 1'b1;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
`ifdef SPI_MISO_SYNC_EN
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            rate_q  <= rate_d;
            first_q <= first_d;
            fmt_q   <= fmt_d;
            fill_q  <= fill_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            din_q   <= din_d;
            owner_q <= owner_d;
            ready_q <= ready_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
`ifdef SPI_MISO_SYNC_EN
            miso_s1_q <= miso_s1_d;
            miso_s2_q <= miso_s2_d;
`endif
        end
    end

    assign f_ready  = ready_q;
    assign f_din    = din_q;
    assign f_owner  = owner_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_flash_phy.sv
// Directed bench for spi_flash_phy: a mode-0 flash model returns a preset byte on MISO while
// framing, bit timing, MOSI data, f_din/f_owner and reset behaviour are checked against hand-computed values.
module tb_spi_flash_phy;

    logic       clk;
    logic       arstn;
    logic       f_ready;
    logic       f_wr;
    logic       f_who;
    logic [7:0] f_dout;
    logic [2:0] f_format;
    logic [3:0] f_rate;
    logic [7:0] f_din;
    logic       f_owner;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;

    int checks = 0;
    int errors = 0;

    logic [7:0] miso_byte = 8'h00;
    logic [2:0] miso_idx  = 3'd0;

    spi_flash_phy dut (
        .clk      (clk),
        .arstn    (arstn),
        .f_ready  (f_ready),
        .f_wr     (f_wr),
        .f_who    (f_who),
        .f_dout   (f_dout),
        .f_format (f_format),
        .f_rate   (f_rate),
        .f_din    (f_din),
        .f_owner  (f_owner),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-0 flash: next bit appears on each falling SCLK, MSB first.
    assign spi_miso = miso_byte[3'd7 - miso_idx];
    always @(negedge spi_sclk) miso_idx <= miso_idx + 3'd1;

    function automatic int hOf(input int r);
`ifdef SPI_MISO_SYNC_EN
        return (r + 1 < 3) ? 3 : r + 1;
`else
        return r + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_cs_n", {7'd0, spi_cs_n}, 8'h01);
        checkOutput("rst_sclk", {7'd0, spi_sclk}, 8'h00);
        checkOutput("rst_mosi", {7'd0, spi_mosi}, 8'h00);
        checkOutput("rst_ready", {7'd0, f_ready}, 8'h01);
        checkOutput("rst_din", f_din, 8'h00);
        checkOutput("rst_owner", {7'd0, f_owner}, 8'h00);
    endtask

    // Issues one byte transfer at the current cycle and checks it cycle by cycle until completion.
    task automatic applyStimulus(input logic [7:0] dout, input logic [2:0] fmt, input logic [3:0] rate,
                                 input logic who, input logic [7:0] mbyte, input int h, input bit midwr);
        logic [7:0] d;
        int bi;
        d = dout;
        miso_byte = mbyte;
        miso_idx  = 3'd0;
        f_dout = dout; f_format = fmt; f_rate = rate; f_who = who; f_wr = 1'b1;
        tick();
        for (int c = 1; c <= 16 * h; c++) begin
            f_wr = 1'b0; f_dout = dout; f_format = fmt; f_who = who;
            bi = (c - 1) / (2 * h);
            checkOutput("sclk", {7'd0, spi_sclk}, {7'd0, 1'(((c - 1) / h) % 2)});
            checkOutput("mosi", {7'd0, spi_mosi}, {7'd0, fmt[2] ? 1'b1 : d[7 - bi]});
            checkOutput("cs_low", {7'd0, spi_cs_n}, 8'h00);
            checkOutput("busy", {7'd0, f_ready}, 8'h00);
            if (midwr && c == 5 * h) begin
                f_wr = 1'b1; f_dout = ~dout; f_format = 3'b001; f_who = ~who;
            end
            tick();
        end
        f_wr = 1'b0; f_dout = dout; f_format = fmt; f_who = who;
        if (fmt[1:0] == 2'b01) begin
            checkOutput("guard_cs", {7'd0, spi_cs_n}, 8'h01);
            checkOutput("guard_sclk", {7'd0, spi_sclk}, 8'h00);
            checkOutput("guard_busy", {7'd0, f_ready}, 8'h00);
            repeat (h - 1) tick();
            checkOutput("guard_end_busy", {7'd0, f_ready}, 8'h00);
            tick();
            checkOutput("guard_cs_hold", {7'd0, spi_cs_n}, 8'h01);
        end else begin
            checkOutput("keep_cs", {7'd0, spi_cs_n}, 8'h00);
        end
        checkOutput("ready", {7'd0, f_ready}, 8'h01);
        checkOutput("din", f_din, mbyte);
        checkOutput("owner", {7'd0, f_owner}, {7'd0, who});
    endtask

    initial begin
        arstn = 1'b1; f_wr = 1'b0; f_who = 1'b0; f_dout = 8'h00; f_format = 3'b010; f_rate = 4'h7;
        #2 arstn = 1'b0;
        #1 checkReset();
        tick(); tick();
        #3 arstn = 1'b1;
        tick();
        checkReset();

        $display("[TB] first transfer, H=8");
        applyStimulus(8'hC3, 3'b010, 4'd7, 1'b0, 8'h5A, 8, 1'b0);

        $display("[TB] rate 0 transfer plus back-to-back bytes");
        applyStimulus(8'h0B, 3'b010, 4'd0, 1'b0, 8'hA5, hOf(0), 1'b0);
        applyStimulus(8'h00, 3'b010, 4'd0, 1'b0, 8'hA5, hOf(0), 1'b0);
        applyStimulus(8'h00, 3'b010, 4'd0, 1'b0, 8'h96, hOf(0), 1'b0);
        applyStimulus(8'h00, 3'b010, 4'd0, 1'b0, 8'hA5, hOf(0), 1'b0);

        $display("[TB] level release while idle");
        f_format = 3'b000;
        checkOutput("pre_release_cs", {7'd0, spi_cs_n}, 8'h00);
        tick();
        checkOutput("release_cs", {7'd0, spi_cs_n}, 8'h01);
        checkOutput("release_ready", {7'd0, f_ready}, 8'h01);
        checkOutput("release_din", f_din, 8'hA5);

        $display("[TB] read-fill format 101 rate 3");
        applyStimulus(8'h12, 3'b101, 4'd3, 1'b1, 8'h3C, hOf(3), 1'b0);

        $display("[TB] f_wr while busy is ignored");
        applyStimulus(8'h5C, 3'b010, 4'd1, 1'b0, 8'hE7, hOf(1), 1'b1);

        $display("[TB] format 000 release via f_wr");
        f_format = 3'b000; f_rate = 4'd2; f_wr = 1'b1;
        tick();
        f_wr = 1'b0; f_format = 3'b010;
        checkOutput("rel_cs", {7'd0, spi_cs_n}, 8'h01);
        checkOutput("rel_sclk", {7'd0, spi_sclk}, 8'h00);
        checkOutput("rel_busy", {7'd0, f_ready}, 8'h00);
        repeat (hOf(2) - 1) tick();
        checkOutput("rel_end_busy", {7'd0, f_ready}, 8'h00);
        tick();
        checkOutput("rel_ready", {7'd0, f_ready}, 8'h01);
        checkOutput("rel_din_hold", f_din, 8'hE7);

        $display("[TB] reset during bit 4");
        miso_byte = 8'hFF; miso_idx = 3'd0;
        f_dout = 8'hAA; f_format = 3'b010; f_rate = 4'd1; f_who = 1'b1; f_wr = 1'b1;
        tick();
        f_wr = 1'b0;
        repeat (4 * hOf(1) * 2) tick();
        checkOutput("abort_busy", {7'd0, f_ready}, 8'h00);
        #2 arstn = 1'b0;
        #1 checkReset();
        #1 arstn = 1'b1;
        tick();
        checkReset();
        applyStimulus(8'h69, 3'b001, 4'd7, 1'b1, 8'h81, 8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
